// File: rtl/wb_format_queue_if.sv
// Result handshake bundle feeding the writeback queue.
// Master drives a beat; slave (the queue) answers with in_ready.
interface wb_format_queue_if #(
   parameter int XLEN = 64,
   parameter int AW   = 5
);
   logic            in_valid;
   logic            in_ready;
   logic [5:0]      in_opcode;
   logic [AW-1:0]   in_rd;
   logic [XLEN-1:0] in_data;

   modport master (
      output in_valid, in_opcode, in_rd, in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_opcode, in_rd, in_data,
      output in_ready
   );
endinterface

// File: rtl/wb_format_queue.sv
// Writeback format/queue stage: formats results, retires one write per cycle.
// Optional WB_FWD_EN adds youngest-match forwarding data for rs/rt.
module wb_format_queue #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 64,
   parameter int AW    = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   wb_format_queue_if.slave    in_if,
   input  logic                wb_stall,
   input  logic                flush,
   input  logic [AW-1:0]       rs,
   input  logic [AW-1:0]       rt,
   output logic                hazard_rs,
   output logic                hazard_rt,
`ifdef WB_FWD_EN
   output logic [XLEN-1:0]     fwd_rs_data,
   output logic [XLEN-1:0]     fwd_rt_data,
`endif
   output logic                reg_write,
   output logic [AW-1:0]       reg_wr_addr,
   output logic [XLEN-1:0]     reg_wr_data,
   output logic                err_illegal
);

   localparam int CW = $clog2(DEPTH);
   localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

   localparam logic [5:0] OP_B  = 6'd34;
   localparam logic [5:0] OP_H  = 6'd40;
   localparam logic [5:0] OP_WS = 6'd42;
   localparam logic [5:0] OP_WZ = 6'd32;
   localparam logic [5:0] OP_D  = 6'd48;

   logic [AW-1:0]   rd_q  [DEPTH];
   logic [XLEN-1:0] dat_q [DEPTH];
   logic [CW-1:0]   head;
   logic [CW-1:0]   tail;
   logic [CW:0]     count;

   logic            legal;
   logic            accept;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] fmt_data;

   function automatic logic [XLEN-1:0] fmt(
      input logic [5:0]      op,
      input logic [XLEN-1:0] d
   );
      logic [XLEN-1:0] r;
      r = '0;
      case (op)
         OP_B:    r = {{(XLEN-8){1'b0}}, d[7:0]};
         OP_H:    r = {{(XLEN-16){1'b0}}, d[15:0]};
         OP_WZ:   r = {{(XLEN-32){1'b0}}, d[31:0]};
         OP_WS:   r = {{(XLEN-32){d[31]}}, d[31:0]};
         OP_D:    r = d;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Any pending write (queued or on the write port) targeting r.
   function automatic logic hit(input logic [AW-1:0] r);
      logic          h;
      logic [CW-1:0] idx;
      h = reg_write && (reg_wr_addr == r);
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + CW'(k);
         if (((CW+1)'(k) < count) && (rd_q[idx] == r))
            h = 1'b1;
      end
      return h;
   endfunction

`ifdef WB_FWD_EN
   // Walk oldest to youngest so the youngest match wins.
   function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] r);
      logic [XLEN-1:0] v;
      logic [CW-1:0]   idx;
      v = '0;
      if (reg_write && (reg_wr_addr == r))
         v = reg_wr_data;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + CW'(k);
         if (((CW+1)'(k) < count) && (rd_q[idx] == r))
            v = dat_q[idx];
      end
      return v;
   endfunction
`endif

   assign in_if.in_ready = (count < FULL);
   assign legal = (in_if.in_opcode == OP_B)  ||
                  (in_if.in_opcode == OP_H)  ||
                  (in_if.in_opcode == OP_WS) ||
                  (in_if.in_opcode == OP_WZ) ||
                  (in_if.in_opcode == OP_D);
   assign accept   = in_if.in_valid && in_if.in_ready && !flush;
   assign push     = accept && legal;
   assign pop      = (count != '0) && !wb_stall && !flush;
   assign fmt_data = fmt(in_if.in_opcode, in_if.in_data);

   // Hazard detection against every pending write.
   always_comb begin
      hazard_rs = hit(rs);
      hazard_rt = hit(rt);
   end

`ifdef WB_FWD_EN
   // Forwarding data follows the hazard flag; zero when no match.
   always_comb begin
      fwd_rs_data = fwd(rs);
      fwd_rt_data = fwd(rt);
   end
`endif

   // Queue storage: formatted beat lands at the tail on push.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_q[tail]  <= in_if.in_rd;
         dat_q[tail] <= fmt_data;
      end
   end

   // Pointers, occupancy, write port and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         reg_write   <= 1'b0;
         reg_wr_addr <= '0;
         reg_wr_data <= '0;
         err_illegal <= 1'b0;
      end else if (flush) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         reg_write <= 1'b0;
      end else begin
         reg_write <= pop;
         if (push)
            tail <= tail + 1'b1;
         if (pop) begin
            head        <= head + 1'b1;
            reg_wr_addr <= rd_q[head];
            reg_wr_data <= dat_q[head];
         end
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
         if (accept && !legal)
            err_illegal <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_format_queue.sv
// Directed bench for wb_format_queue.
// Define WB_FWD_EN to also check forwarding data.
module tb_wb_format_queue;

   logic        clk;
   logic        rst_n;
   logic        wb_stall;
   logic        flush;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        hazard_rs;
   logic        hazard_rt;
   logic        reg_write;
   logic [4:0]  reg_wr_addr;
   logic [63:0] reg_wr_data;
   logic        err_illegal;
`ifdef WB_FWD_EN
   logic [63:0] fwd_rs_data;
   logic [63:0] fwd_rt_data;
`endif

   int n_chk;
   int n_fail;

   wb_format_queue_if #(.XLEN(64), .AW(5)) bus ();

   wb_format_queue #(.DEPTH(2), .XLEN(64), .AW(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_if       (bus),
      .wb_stall    (wb_stall),
      .flush       (flush),
      .rs          (rs),
      .rt          (rt),
      .hazard_rs   (hazard_rs),
      .hazard_rt   (hazard_rt),
`ifdef WB_FWD_EN
      .fwd_rs_data (fwd_rs_data),
      .fwd_rt_data (fwd_rt_data),
`endif
      .reg_write   (reg_write),
      .reg_wr_addr (reg_wr_addr),
      .reg_wr_data (reg_wr_data),
      .err_illegal (err_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] op,
                        input logic [4:0] rd, input logic [63:0] d);
      bus.in_valid  = v;
      bus.in_opcode = op;
      bus.in_rd     = rd;
      bus.in_data   = d;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n    = 1'b0;
      wb_stall = 1'b0;
      flush    = 1'b0;
      rs       = 5'd0;
      rt       = 5'd0;
      drive(1'b0, 6'd0, 5'd0, 64'd0);

      // reset state
      step();
      step();
      chk("rst_rw",    reg_write,   0);
      chk("rst_addr",  reg_wr_addr, 0);
      chk("rst_data",  reg_wr_data, 0);
      chk("rst_err",   err_illegal, 0);
      chk("rst_ready", bus.in_ready, 1);
      chk("rst_hzrs",  hazard_rs,   0);
      chk("rst_hzrt",  hazard_rt,   0);
      #3 rst_n = 1'b1;
      step();

      // byte format and latency
      drive(1'b1, 6'd34, 5'd3, 64'hFFFF_FFFF_FFFF_FF80);
      step();
      drive(1'b0, 6'd0, 5'd0, 64'd0);
      chk("lat_k",  reg_write, 0);
      step();
      chk("b_rw",   reg_write,   1);
      chk("b_addr", reg_wr_addr, 3);
      chk("b_data", reg_wr_data, 64'h80);
      step();
      chk("b_pulse", reg_write, 0);

      // sign extend word
      drive(1'b1, 6'd42, 5'd4, 64'h0000_0000_8000_0001);
      step();
      drive(1'b0, 6'd0, 5'd0, 64'd0);
      step();
      chk("ws_addr", reg_wr_addr, 4);
      chk("ws_data", reg_wr_data, 64'hFFFF_FFFF_8000_0001);

      // zero extend word
      drive(1'b1, 6'd32, 5'd5, 64'h0000_0000_8000_0001);
      step();
      drive(1'b0, 6'd0, 5'd0, 64'd0);
      step();
      chk("wz_data", reg_wr_data, 64'h0000_0000_8000_0001);

      // halfword, then doubleword
      drive(1'b1, 6'd40, 5'd6, 64'h1234_5678_9ABC_DEF0);
      step();
      drive(1'b1, 6'd48, 5'd6, 64'h1234_5678_9ABC_DEF0);
      step();
      drive(1'b0, 6'd0, 5'd0, 64'd0);
      chk("h_data", reg_wr_data, 64'hDEF0);
      step();
      chk("d_data", reg_wr_data, 64'h1234_5678_9ABC_DEF0);
      step();

      // fill under stall
      wb_stall = 1'b1;
      drive(1'b1, 6'd48, 5'd10, 64'd1);
      step();
      chk("fill_rdy1", bus.in_ready, 1);
      drive(1'b1, 6'd48, 5'd11, 64'd2);
      step();
      chk("fill_rdy2", bus.in_ready, 0);
      drive(1'b1, 6'd48, 5'd12, 64'd3);
      step();
      chk("fill_hold", bus.in_ready, 0);
      chk("stall_rw",  reg_write,    0);
      wb_stall = 1'b0;
      step();
      chk("ret1_rw",   reg_write,   1);
      chk("ret1_addr", reg_wr_addr, 10);
      chk("ret1_rdy",  bus.in_ready, 1);
      step();
      drive(1'b0, 6'd0, 5'd0, 64'd0);
      chk("ret2_rw",   reg_write,   1);
      chk("ret2_addr", reg_wr_addr, 11);
      step();
      chk("ret3_rw",   reg_write,   1);
      chk("ret3_addr", reg_wr_addr, 12);
      chk("ret3_data", reg_wr_data, 3);
      step();
      chk("ret_done", reg_write, 0);

      // hazard on a pending write
      wb_stall = 1'b1;
      drive(1'b1, 6'd48, 5'd7, 64'h1234);
      step();
      drive(1'b0, 6'd0, 5'd0, 64'd0);
      rs = 5'd7;
      rt = 5'd8;
      #1;
      chk("hz_rs7", hazard_rs, 1);
      chk("hz_rt8", hazard_rt, 0);
`ifdef WB_FWD_EN
      chk("fwd_rs", fwd_rs_data, 64'h1234);
      chk("fwd_rt", fwd_rt_data, 0);
`endif
      rs = 5'd8;
      #1;
      chk("hz_rs8", hazard_rs, 0);
      rs = 5'd7;
      wb_stall = 1'b0;
      step();
      chk("hz_ret_rw", reg_write, 1);
      chk("hz_ret",    hazard_rs, 1);
      step();
      chk("hz_clear",  hazard_rs, 0);

      // flush discards pending writes
      wb_stall = 1'b1;
      drive(1'b1, 6'd48, 5'd20, 64'd5);
      step();
      drive(1'b1, 6'd48, 5'd21, 64'd6);
      step();
      drive(1'b0, 6'd0, 5'd0, 64'd0);
      rs = 5'd20;
      #1;
      chk("fl_hz_pre", hazard_rs, 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      wb_stall = 1'b0;
      chk("fl_rw",  reg_write,    0);
      chk("fl_rdy", bus.in_ready, 1);
      chk("fl_hz",  hazard_rs,    0);
      step();
      chk("fl_rw1", reg_write, 0);
      step();
      chk("fl_rw2", reg_write, 0);

      // illegal opcode
      drive(1'b1, 6'd5, 5'd9, 64'hAA);
      rs = 5'd9;
      #1;
      chk("il_rdy_pre", bus.in_ready, 1);
      step();
      drive(1'b0, 6'd0, 5'd0, 64'd0);
      chk("il_err", err_illegal,  1);
      chk("il_rdy", bus.in_ready, 1);
      chk("il_hz",  hazard_rs,    0);
      step();
      chk("il_rw",  reg_write,   0);
      chk("il_sticky", err_illegal, 1);

      // reset mid-stream
      wb_stall = 1'b1;
      drive(1'b1, 6'd48, 5'd14, 64'd7);
      step();
      drive(1'b1, 6'd48, 5'd15, 64'd8);
      step();
      drive(1'b0, 6'd0, 5'd0, 64'd0);
      chk("mr_full", bus.in_ready, 0);
      wb_stall = 1'b0;
      step();
      chk("mr_rw_pre", reg_write, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_rw",   reg_write,    0);
      chk("mr_rdy",  bus.in_ready, 1);
      chk("mr_addr", reg_wr_addr,  0);
      chk("mr_err",  err_illegal,  0);
      step();
      #2 rst_n = 1'b1;
      step();
      chk("mr_post1", reg_write, 0);
      step();
      chk("mr_post2", reg_write, 0);
      step();
      chk("mr_post3", reg_write, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
